// File: rtl/dose_alarm_controller_if.sv
// Signal bundle between the next-pill monitor / button shaper (master) and the
// dose alarm controller (slave). Every input is a level or a one-clk strobe, and no input has backpressure.
interface dose_alarm_controller_if;
    logic       run;
    logic       secondTick;
    logic [3:0] nextPill;
    logic [3:0] hoursUntil;
    logic       ackPulse;
    logic       snoozePulse;
    logic       buzzer;
    logic       alarmLed;
    logic [3:0] activePill;
    logic [7:0] takenCount;
    logic [7:0] missedCount;
    logic       missedEvent;

    modport master (
        output run, secondTick, nextPill, hoursUntil, ackPulse, snoozePulse,
        input  buzzer, alarmLed, activePill, takenCount, missedCount, missedEvent
    );

    modport slave (
        input  run, secondTick, nextPill, hoursUntil, ackPulse, snoozePulse,
        output buzzer, alarmLed, activePill, takenCount, missedCount, missedEvent
    );
endinterface

// File: rtl/dose_alarm_controller.sv
// Dose alarm FSM: rings, snoozes and times out each due dose, and counts taken and missed doses.
// Optional macro ALARM_ESCALATION_EN makes the buzzer chirp with the LED until the first snooze.
module dose_alarm_controller #(
    parameter int         RING_TIMEOUT_S = 300,
    parameter int         SNOOZE_S       = 60,
    parameter int         MAX_SNOOZES    = 3,
    parameter logic [3:0] NO_PILL        = 4'hF
) (
    input  logic                    clk,
    input  logic                    reset,
    dose_alarm_controller_if.slave  bus,
    output logic [1:0]              stateDbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2, MISSED = 2'd3} state_t;

    localparam logic [15:0] RING_TC = 16'(RING_TIMEOUT_S);
    localparam logic [15:0] SNOOZE_TC = 16'(SNOOZE_S);
    localparam logic [7:0]  MAX_SNZ = 8'(MAX_SNOOZES);

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  snoozeCnt;
    logic [3:0]  servedId;
    logic        buzzerQ;
    logic        alarmLedQ;
    logic [3:0]  activePillQ;
    logic [7:0]  takenCnt;
    logic [7:0]  missedCnt;
    logic        missedEvtQ;

    logic [15:0] timerNext;
    logic        due;
    logic        ringBuzz;

    assign timerNext = timer + 16'd1;
    assign due = bus.run && (bus.hoursUntil == 4'd0) && (bus.nextPill != NO_PILL);

    // Buzzer value for the ringing cycle after an LED toggle.
`ifdef ALARM_ESCALATION_EN
    assign ringBuzz = (snoozeCnt == 8'd0) ? ~alarmLedQ : 1'b1;
`else
    assign ringBuzz = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= 16'd0;
            snoozeCnt   <= 8'd0;
            servedId    <= NO_PILL;
            buzzerQ     <= 1'b0;
            alarmLedQ   <= 1'b0;
            activePillQ <= NO_PILL;
            takenCnt    <= 8'd0;
            missedCnt   <= 8'd0;
            missedEvtQ  <= 1'b0;
        end else begin
            missedEvtQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (due && (bus.nextPill != servedId)) begin
                        state       <= RINGING;
                        activePillQ <= bus.nextPill;
                        timer       <= 16'd0;
                        snoozeCnt   <= 8'd0;
                        buzzerQ     <= 1'b1;
                        alarmLedQ   <= 1'b1;
                    end
                end
                RINGING: begin
                    if (!bus.run) begin
                        state       <= IDLE;
                        buzzerQ     <= 1'b0;
                        alarmLedQ   <= 1'b0;
                        activePillQ <= NO_PILL;
                    end else if (bus.ackPulse) begin
                        state       <= IDLE;
                        buzzerQ     <= 1'b0;
                        alarmLedQ   <= 1'b0;
                        activePillQ <= NO_PILL;
                        servedId    <= activePillQ;
                        if (takenCnt != 8'hFF) takenCnt <= takenCnt + 8'd1;
                    end else if (bus.snoozePulse && (snoozeCnt < MAX_SNZ)) begin
                        state     <= SNOOZE;
                        snoozeCnt <= snoozeCnt + 8'd1;
                        timer     <= 16'd0;
                        buzzerQ   <= 1'b0;
                        alarmLedQ <= 1'b1;
                    end else if (bus.secondTick) begin
                        timer <= timerNext;
                        if (timerNext == RING_TC) begin
                            state      <= MISSED;
                            missedEvtQ <= 1'b1;
                            buzzerQ    <= 1'b0;
                            alarmLedQ  <= 1'b0;
                            if (missedCnt != 8'hFF) missedCnt <= missedCnt + 8'd1;
                        end else begin
                            alarmLedQ <= ~alarmLedQ;
                            buzzerQ   <= ringBuzz;
                        end
                    end
                end
                SNOOZE: begin
                    if (!bus.run) begin
                        state       <= IDLE;
                        buzzerQ     <= 1'b0;
                        alarmLedQ   <= 1'b0;
                        activePillQ <= NO_PILL;
                    end else if (bus.ackPulse) begin
                        state       <= IDLE;
                        buzzerQ     <= 1'b0;
                        alarmLedQ   <= 1'b0;
                        activePillQ <= NO_PILL;
                        servedId    <= activePillQ;
                        if (takenCnt != 8'hFF) takenCnt <= takenCnt + 8'd1;
                    end else if (bus.secondTick) begin
                        if (timerNext == SNOOZE_TC) begin
                            state     <= RINGING;
                            timer     <= 16'd0;
                            buzzerQ   <= 1'b1;
                            alarmLedQ <= 1'b1;
                        end else begin
                            timer <= timerNext;
                        end
                    end
                end
                MISSED: begin
                    state       <= IDLE;
                    servedId    <= activePillQ;
                    activePillQ <= NO_PILL;
                end
                default: state <= IDLE;
            endcase
            // A nonzero hours value means the dose moved on; rearm so the pill rings again next time.
            if (bus.hoursUntil != 4'd0) servedId <= NO_PILL;
        end
    end

    assign bus.buzzer      = buzzerQ;
    assign bus.alarmLed    = alarmLedQ;
    assign bus.activePill  = activePillQ;
    assign bus.takenCount  = takenCnt;
    assign bus.missedCount = missedCnt;
    assign bus.missedEvent = missedEvtQ;
    assign stateDbg        = state;
endmodule
